// File: rtl/rx_cmd_sequencer.sv
// Frames the UART byte stream into 4-byte motor commands (HEADER, L, R, CS) with inter-byte timeout and link watchdog.
// Optional RX_CMD_ERR_COUNT_EN adds a saturating err_count output cleared by every good frame.
module rx_cmd_sequencer #(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter logic [31:0] BYTE_TIMEOUT = 32'd16670,
    parameter logic [31:0] SLEEP_CYCLES = 32'd48000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] left_cmd,
    output logic [7:0] right_cmd,
    output logic       cmd_valid,
    output logic       frame_err,
`ifdef RX_CMD_ERR_COUNT_EN
    output logic [7:0] err_count,
`endif
    output logic       link_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_L  = 2'd1,
        GET_R  = 2'd2,
        GET_CS = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_byte_cnt;
    logic [31:0] r_wd_cnt;
    logic [7:0]  r_hold_l;
    logic [7:0]  r_hold_r;
    logic [7:0]  r_left_cmd;
    logic [7:0]  r_right_cmd;
    logic        r_cmd_valid;
    logic        r_frame_err;
    logic        r_link_timeout;

    logic        w_cs_ok;
    logic        w_good;
    logic        w_byte_to;
    logic        w_err_pulse;

    // A byte arriving in the same cycle as the timeout wins, so the timeout is gated by !rx_done.
    assign w_cs_ok     = (rx_data == (HEADER ^ r_hold_l ^ r_hold_r));
    assign w_good      = rx_done && (r_state == GET_CS) && w_cs_ok;
    assign w_byte_to   = !rx_done && (r_state != IDLE) && (r_byte_cnt == BYTE_TIMEOUT);
    assign w_err_pulse = (rx_done && (r_state == GET_CS) && !w_cs_ok) || w_byte_to;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_byte_cnt     <= '0;
            r_wd_cnt       <= '0;
            r_hold_l       <= '0;
            r_hold_r       <= '0;
            r_left_cmd     <= '0;
            r_right_cmd    <= '0;
            r_cmd_valid    <= 1'b0;
            r_frame_err    <= 1'b0;
            r_link_timeout <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_frame_err <= w_err_pulse;

            if (rx_done) begin
                r_byte_cnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (rx_data == HEADER) begin
                            r_state <= GET_L;
                        end
                    end
                    GET_L: begin
                        r_hold_l <= rx_data;
                        r_state  <= GET_R;
                    end
                    GET_R: begin
                        r_hold_r <= rx_data;
                        r_state  <= GET_CS;
                    end
                    GET_CS: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end else if (r_state != IDLE) begin
                if (w_byte_to) begin
                    r_state    <= IDLE;
                    r_byte_cnt <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 32'd1;
                end
            end

            // A good frame takes priority over watchdog expiry in the same cycle.
            if (w_good) begin
                r_wd_cnt       <= '0;
                r_left_cmd     <= r_hold_l;
                r_right_cmd    <= r_hold_r;
                r_cmd_valid    <= 1'b1;
                r_link_timeout <= 1'b0;
            end else if (r_wd_cnt == SLEEP_CYCLES) begin
                r_left_cmd     <= '0;
                r_right_cmd    <= '0;
                r_link_timeout <= 1'b1;
            end else begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
        end
    end

`ifdef RX_CMD_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= '0;
        end else if (w_good) begin
            r_err_count <= '0;
        end else if (w_err_pulse && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign left_cmd     = r_left_cmd;
    assign right_cmd    = r_right_cmd;
    assign cmd_valid    = r_cmd_valid;
    assign frame_err    = r_frame_err;
    assign link_timeout = r_link_timeout;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Scoreboard bench for rx_cmd_sequencer: expected pulses are queued by the stimulus and consumed by a monitor.
module tb_rx_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] left_cmd;
    logic [7:0] right_cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       link_timeout;
`ifdef RX_CMD_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    typedef struct {
        bit         isErr;
        logic [7:0] left;
        logic [7:0] right;
        logic       link;
    } exp_t;

    exp_t sbQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    rx_cmd_sequencer #(
        .HEADER      (8'hA5),
        .BYTE_TIMEOUT(32'd20),
        .SLEEP_CYCLES(32'd200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .left_cmd    (left_cmd),
        .right_cmd   (right_cmd),
        .cmd_valid   (cmd_valid),
        .frame_err   (frame_err),
`ifdef RX_CMD_ERR_COUNT_EN
        .err_count   (err_count),
`endif
        .link_timeout(link_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int gap);
        @(posedge clk);
        #1;
        rx_data = d;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (gap) @(posedge clk);
    endtask

    task automatic expectPulse(input bit isErr, input logic [7:0] l, input logic [7:0] r, input logic link);
        exp_t e;
        e.isErr = isErr;
        e.left  = l;
        e.right = r;
        e.link  = link;
        sbQ.push_back(e);
    endtask

    task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        applyStimulus(b0, 5);
        applyStimulus(b1, 5);
        applyStimulus(b2, 5);
        applyStimulus(b3, 5);
    endtask

    // Any pulse with nothing queued is itself a failure, which also catches pulses wider than one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && (cmd_valid || frame_err)) begin
                if (sbQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpectedPulse: got cmd_valid=%0b frame_err=%0b expected none", cmd_valid, frame_err);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("pulseFrameErr", {31'd0, frame_err}, {31'd0, e.isErr});
                    checkOutput("pulseCmdValid", {31'd0, cmd_valid}, {31'd0, !e.isErr});
                    checkOutput("pulseLeft", {24'd0, left_cmd}, {24'd0, e.left});
                    checkOutput("pulseRight", {24'd0, right_cmd}, {24'd0, e.right});
                    checkOutput("pulseLink", {31'd0, link_timeout}, {31'd0, e.link});
                end
            end
        end
    end

    initial begin
        rst     = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstLeft", {24'd0, left_cmd}, 32'h0);
        checkOutput("rstRight", {24'd0, right_cmd}, 32'h0);
        checkOutput("rstValid", {31'd0, cmd_valid}, 32'h0);
        checkOutput("rstErr", {31'd0, frame_err}, 32'h0);
        checkOutput("rstLink", {31'd0, link_timeout}, 32'h0);
        rst = 1'b1;

        expectPulse(1'b0, 8'h10, 8'h20, 1'b0);
        sendFrame(8'hA5, 8'h10, 8'h20, 8'h95);

        expectPulse(1'b1, 8'h10, 8'h20, 1'b0);
        sendFrame(8'hA5, 8'h10, 8'h20, 8'h00);
        expectPulse(1'b0, 8'h01, 8'h02, 1'b0);
        sendFrame(8'hA5, 8'h01, 8'h02, 8'hA6);

        $display("[TB] inter-byte timeout");
        expectPulse(1'b1, 8'h01, 8'h02, 1'b0);
        applyStimulus(8'hA5, 5);
        applyStimulus(8'h10, 0);
        repeat (25) @(posedge clk);
        #1;
        checkOutput("timeoutSeen", sbQ.size(), 32'd0);
        applyStimulus(8'h20, 5);
        applyStimulus(8'h95, 5);

        applyStimulus(8'h33, 3);
        applyStimulus(8'h44, 3);
        expectPulse(1'b0, 8'hA5, 8'hA5, 1'b0);
        sendFrame(8'hA5, 8'hA5, 8'hA5, 8'hA5);

        $display("[TB] watchdog");
        repeat (190) @(posedge clk);
        #1;
        checkOutput("wdBeforeLink", {31'd0, link_timeout}, 32'h0);
        checkOutput("wdBeforeLeft", {24'd0, left_cmd}, 32'hA5);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("wdLink", {31'd0, link_timeout}, 32'h1);
        checkOutput("wdLeft", {24'd0, left_cmd}, 32'h0);
        checkOutput("wdRight", {24'd0, right_cmd}, 32'h0);
        expectPulse(1'b0, 8'h05, 8'h06, 1'b0);
        sendFrame(8'hA5, 8'h05, 8'h06, 8'hA6);
        checkOutput("wdRecoverLink", {31'd0, link_timeout}, 32'h0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5, 2);
        applyStimulus(8'h10, 2);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midRstLeft", {24'd0, left_cmd}, 32'h0);
        checkOutput("midRstRight", {24'd0, right_cmd}, 32'h0);
        checkOutput("midRstLink", {31'd0, link_timeout}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expectPulse(1'b0, 8'h01, 8'h02, 1'b0);
        sendFrame(8'hA5, 8'h01, 8'h02, 8'hA6);

`ifdef RX_CMD_ERR_COUNT_EN
        for (int i = 0; i < 3; i++) begin
            expectPulse(1'b1, 8'h01, 8'h02, 1'b0);
            sendFrame(8'hA5, 8'h01, 8'h02, 8'h00);
        end
        checkOutput("errCount3", {24'd0, err_count}, 32'd3);
        expectPulse(1'b0, 8'h03, 8'h04, 1'b0);
        sendFrame(8'hA5, 8'h03, 8'h04, 8'hA2);
        checkOutput("errCountClr", {24'd0, err_count}, 32'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queueDrained", sbQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
